// File: rtl/zuc_core.sv
// zuc_core: ZUC keystream generator (128-EEA3/EIA3 core).
// 16x31-bit LFSR over GF(2^31-1), bit reorganization, nonlinear F with S0/S1.
// Build option: define ZUC_ZERO_IDLE_EN to force Z to zero whenever Done is low;
// otherwise Z holds its last keystream word while Done is low.
module zuc_core (
    input  logic         clk,
    input  logic         rstn,
    input  logic         init,
    input  logic         start,
    input  logic [127:0] KEY,
    input  logic [127:0] IV,
    output logic [31:0]  Z,
    output logic         Done
);

`ifdef ZUC_ZERO_IDLE_EN
    localparam bit ZERO_IDLE = 1'b1;
`else
    localparam bit ZERO_IDLE = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOADED, INITRUN, DISCARD, KEYSTREAM} state_t;

    // Loading constants d0..d15 (15 bits each), d0 in the most significant slot.
    localparam logic [239:0] DCONST = {
        15'h44D7, 15'h26BC, 15'h626B, 15'h135E, 15'h5789, 15'h35E2, 15'h7135, 15'h09AF,
        15'h4D78, 15'h2F13, 15'h6BC4, 15'h1AF1, 15'h5E26, 15'h3C4D, 15'h789A, 15'h47AC
    };

    // S-box tables, entry 0 in the most significant byte.
    localparam logic [2047:0] S0_TAB = {
        128'h3e725b47cae0003304d1549809b96dcb, 128'h7b1bf932af9d6aa5b82dfc1d08530390,
        128'h4d4e8499e4ced991ddb685488b296eac, 128'hcdc1f81e734369c6b5bdfd396320d438,
        128'h767db2a7cfed57c5f32cbb142106559b, 128'he3ef5e314f7f5aa40d8251495fba581c,
        128'h4a16d517a892241f8cffd8ae2e01d3ad, 128'h3b4bda46ebc9de9a8f87d73a806f2fc8,
        128'hb1b437f70a2213287ccc3c89c7c39656, 128'h07bf7ef00b2b975235417961a64c10fe,
        128'hbc2695888ab0a3fbc01894f2e1e5e95d, 128'hd0dc1166645cec59427512f5749caa23,
        128'h0e86abbe2a02e767e644a26cc2939ff1, 128'hf6fa36d250689e6271153dd640c4e20f,
        128'h8e83776b25053f0c30ea70b7a1e8a965, 128'h8d271adb81b3a0f4457a19dfee783460
    };
    localparam logic [2047:0] S1_TAB = {
        128'h55c263713bc847869f3cda5b29aafd77, 128'h8cc5940ca61a1300e3a8167240f9f842,
        128'h4426689681d9453e1076c6a78b3943e1, 128'h3ab5562ac06db3052266bfdc0bfa6248,
        128'hdd20110636c9c1cff62752bb69f5d487, 128'h7f844cd29c57a4bc4f9adffed68d7aeb,
        128'h2b53d85ca11417fb23d57d3067730809, 128'heeb7703f61b2198e4ee54b938f5ddba9,
        128'hadf1ae2ecb0dfcf42d466e1d97e8d1e9, 128'h4d37a5755e839eab829db91ce0cd4989,
        128'h01b6bd5824a25f387899159050b895e4, 128'hd091c7ceed0fb46fa0ccf0024a79c3de,
        128'ha3efea51e66b18ec1b2c80f774e7ff21, 128'h5a6a541e41319235c433070aba7e0e34,
        128'h88b1987cf33d606c7bcad31f32650428, 128'h64be859b2f598ad7b025acaf1203e2f2
    };

    function automatic logic [7:0] sb0(input logic [7:0] x);
        return S0_TAB[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] sb1(input logic [7:0] x);
        return S1_TAB[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [31:0] sbox(input logic [31:0] x);
        return {sb0(x[31:24]), sb1(x[23:16]), sb0(x[15:8]), sb1(x[7:0])};
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned k);
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic logic [31:0] lin1(input logic [31:0] x);
        return x ^ rotl32(x, 2) ^ rotl32(x, 10) ^ rotl32(x, 18) ^ rotl32(x, 24);
    endfunction

    function automatic logic [31:0] lin2(input logic [31:0] x);
        return x ^ rotl32(x, 8) ^ rotl32(x, 14) ^ rotl32(x, 22) ^ rotl32(x, 30);
    endfunction

    // Multiplication by 2^k mod (2^31-1) is a 31-bit left rotate.
    function automatic logic [30:0] rot31(input logic [30:0] x, input int unsigned k);
        return (x << k) | (x >> (31 - k));
    endfunction

    // Addition mod (2^31-1) with end-around carry.
    function automatic logic [30:0] add31(input logic [30:0] a, input logic [30:0] b);
        logic [31:0] c;
        c = {1'b0, a} + {1'b0, b};
        return c[30:0] + {30'b0, c[31]};
    endfunction

    state_t      state;
    logic [4:0]  cnt;
    logic [30:0] s [16];
    logic [31:0] r1, r2;

    logic [31:0] x0, x1, x2, x3;
    logic [31:0] w, w1, w2, r1_nxt, r2_nxt;
    logic [30:0] fb_v, fb_raw, s16;

    // Bit reorganization, F function and LFSR feedback from the current state.
    always_comb begin
        x0 = {s[15][30:15], s[14][15:0]};
        x1 = {s[11][15:0], s[9][30:15]};
        x2 = {s[7][15:0],  s[5][30:15]};
        x3 = {s[2][15:0],  s[0][30:15]};
        w  = (x0 ^ r1) + r2;
        w1 = r1 + x1;
        w2 = r2 ^ x2;
        r1_nxt = sbox(lin1({w1[15:0], w2[31:16]}));
        r2_nxt = sbox(lin2({w2[15:0], w1[31:16]}));

        fb_v = add31(s[0], rot31(s[0], 8));
        fb_v = add31(fb_v, rot31(s[4], 20));
        fb_v = add31(fb_v, rot31(s[10], 21));
        fb_v = add31(fb_v, rot31(s[13], 17));
        fb_v = add31(fb_v, rot31(s[15], 15));
        fb_raw = (state == INITRUN) ? add31(fb_v, w[31:1]) : fb_v;
        s16 = (fb_raw == '0) ? 31'h7FFFFFFF : fb_raw;
    end

    // Control FSM, LFSR/FSM registers and registered keystream output.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state <= IDLE;
            cnt   <= '0;
            r1    <= '0;
            r2    <= '0;
            Z     <= '0;
            Done  <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) s[i] <= '0;
        end else if (init) begin
            for (int unsigned i = 0; i < 16; i++)
                s[i] <= {KEY[127 - 8*i -: 8], DCONST[239 - 15*i -: 15], IV[127 - 8*i -: 8]};
            r1    <= '0;
            r2    <= '0;
            cnt   <= '0;
            state <= LOADED;
            Done  <= 1'b0;
            if (ZERO_IDLE) Z <= '0;
        end else begin
            if (state inside {INITRUN, DISCARD, KEYSTREAM}) begin
                for (int unsigned i = 0; i < 15; i++) s[i] <= s[i + 1];
                s[15] <= s16;
                r1    <= r1_nxt;
                r2    <= r2_nxt;
            end
            case (state)
                LOADED: begin
                    if (start) begin
                        state <= INITRUN;
                        cnt   <= '0;
                    end
                    if (ZERO_IDLE) Z <= '0;
                end
                INITRUN: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= DISCARD;
                    if (ZERO_IDLE) Z <= '0;
                end
                DISCARD: begin
                    state <= KEYSTREAM;
                    if (ZERO_IDLE) Z <= '0;
                end
                KEYSTREAM: begin
                    Z    <= w ^ x3;
                    Done <= 1'b1;
                end
                default: begin
                    if (ZERO_IDLE) Z <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zuc_core.sv
// tb_zuc_core: directed self-checking bench for zuc_core using the standard
// ZUC test vectors; expects the gap value of Z according to ZUC_ZERO_IDLE_EN.
module tb_zuc_core;

    logic         clk;
    logic         rstn;
    logic         init;
    logic         start;
    logic [127:0] KEY;
    logic [127:0] IV;
    logic [31:0]  Z;
    logic         Done;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] K3  = 128'h3D4C4BE96A82FDAEB58F641DB17B455B;
    localparam logic [127:0] IV3 = 128'h84319AA8DE6915CA1F6BDA6BFBD8C766;

    zuc_core dut (
        .clk   (clk),
        .rstn  (rstn),
        .init  (init),
        .start (start),
        .KEY   (KEY),
        .IV    (IV),
        .Z     (Z),
        .Done  (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive init (optionally with start) for one edge; returns 1 ns after that edge.
    task automatic load_key(input logic [127:0] k, input logic [127:0] v, input logic with_start);
        @(negedge clk);
        KEY = k;
        IV = v;
        init = 1'b1;
        start = with_start;
        @(posedge clk);
        #1;
        init = 1'b0;
        start = 1'b0;
    endtask

    // Pulse start for one edge (E0); returns 1 ns after E0.
    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (Z !== 32'h0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: Z=%h Done=%b expected Z=00000000 Done=0", Z, Done);
        end
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (Z !== 32'h0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: Z=%h Done=%b expected Z=00000000 Done=0", Z, Done);
        end
    endtask

    task automatic test_vectors;
        logic [127:0] keys [3];
        logic [127:0] ivs  [3];
        logic [31:0]  z1s  [3];
        logic [31:0]  z2s  [3];
        keys[0] = '0;  ivs[0] = '0;  z1s[0] = 32'h27BEDE74; z2s[0] = 32'h018082DA;
        keys[1] = '1;  ivs[1] = '1;  z1s[1] = 32'h0657CFA0; z2s[1] = 32'h7096398B;
        keys[2] = K3;  ivs[2] = IV3; z1s[2] = 32'h14F1C272; z2s[2] = 32'h3279C419;
        for (int v = 0; v < 3; v++) begin
            load_key(keys[v], ivs[v], 1'b0);
            pulse_start;
            repeat (33) @(posedge clk);
            #1;
            checks++;
            if (Done !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_done_e33: Done=%b expected 0", v + 1, Done);
            end
            @(posedge clk);
            #1;
            checks++;
            if (Done !== 1'b1 || Z !== z1s[v]) begin
                errors++;
                $display("FAIL vec%0d_z1: Z=%h Done=%b expected Z=%h Done=1", v + 1, Z, Done, z1s[v]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (Done !== 1'b1 || Z !== z2s[v]) begin
                errors++;
                $display("FAIL vec%0d_z2: Z=%h Done=%b expected Z=%h Done=1", v + 1, Z, Done, z2s[v]);
            end
        end
    endtask

    task automatic test_ignored_start;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        pulse_start;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("FAIL start_without_init: Done=%b expected 0", Done);
        end
        load_key('0, '0, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("FAIL init_and_start: Done=%b expected 0", Done);
        end
        // The combined pulse must still have loaded the key, so a lone start now runs.
        pulse_start;
        repeat (34) @(posedge clk);
        #1;
        checks++;
        if (Done !== 1'b1 || Z !== 32'h27BEDE74) begin
            errors++;
            $display("FAIL start_after_combined: Z=%h Done=%b expected Z=27bede74 Done=1", Z, Done);
        end
    endtask

    task automatic test_abort;
        logic [31:0] gap;
`ifdef ZUC_ZERO_IDLE_EN
        gap = 32'h0;
`else
        gap = 32'h018082DA;
`endif
        load_key('0, '0, 1'b0);
        pulse_start;
        repeat (35) @(posedge clk);
        #1;
        checks++;
        if (Done !== 1'b1 || Z !== 32'h018082DA) begin
            errors++;
            $display("FAIL abort_pre: Z=%h Done=%b expected Z=018082da Done=1", Z, Done);
        end
        load_key(K3, IV3, 1'b0);
        checks++;
        if (Done !== 1'b0 || Z !== gap) begin
            errors++;
            $display("FAIL abort_drop: Z=%h Done=%b expected Z=%h Done=0", Z, Done, gap);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (Done !== 1'b0 || Z !== gap) begin
            errors++;
            $display("FAIL abort_gap: Z=%h Done=%b expected Z=%h Done=0", Z, Done, gap);
        end
        pulse_start;
        repeat (33) @(posedge clk);
        #1;
        checks++;
        if (Done !== 1'b0 || Z !== gap) begin
            errors++;
            $display("FAIL abort_e33: Z=%h Done=%b expected Z=%h Done=0", Z, Done, gap);
        end
        @(posedge clk);
        #1;
        checks++;
        if (Done !== 1'b1 || Z !== 32'h14F1C272) begin
            errors++;
            $display("FAIL abort_z1: Z=%h Done=%b expected Z=14f1c272 Done=1", Z, Done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (Done !== 1'b1 || Z !== 32'h3279C419) begin
            errors++;
            $display("FAIL abort_z2: Z=%h Done=%b expected Z=3279c419 Done=1", Z, Done);
        end
    endtask

    task automatic test_reset_mid;
        load_key('0, '0, 1'b0);
        pulse_start;
        repeat (10) @(posedge clk);
        #2;
        rstn = 1'b1;
        #1;
        checks++;
        if (Z !== 32'h0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: Z=%h Done=%b expected Z=00000000 Done=0", Z, Done);
        end
        @(negedge clk);
        rstn = 1'b0;
        load_key('0, '0, 1'b0);
        pulse_start;
        repeat (34) @(posedge clk);
        #1;
        checks++;
        if (Done !== 1'b1 || Z !== 32'h27BEDE74) begin
            errors++;
            $display("FAIL reset_mid_z1: Z=%h Done=%b expected Z=27bede74 Done=1", Z, Done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (Done !== 1'b1 || Z !== 32'h018082DA) begin
            errors++;
            $display("FAIL reset_mid_z2: Z=%h Done=%b expected Z=018082da Done=1", Z, Done);
        end
    endtask

    initial begin
        rstn  = 1'b1;
        init  = 1'b0;
        start = 1'b0;
        KEY   = '0;
        IV    = '0;
        test_reset;
        test_vectors;
        test_ignored_start;
        test_abort;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
